// File: rtl/quire_to_posit_4_0.sv
// Converts the two's-complement posit<4,0> quire stream into rounded 4-bit posits.
// Input register, then magnitude, normalise and encode stages, all stalled together by process_en.
module quire_to_posit_4_0 #(
  parameter int LOG_NB_ACCUM = 10,
  parameter bit EOW_ONLY     = 1'b1,
  localparam int QUIRE_SIZE  = 9 + LOG_NB_ACCUM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rts_i,
  output logic                  rtr_o,
  input  logic                  sow_i,
  input  logic                  eow_i,
  input  logic [QUIRE_SIZE-1:0] data_i,
  input  logic                  NaR_i,
  input  logic                  rtr_i,
  output logic                  rts_o,
  output logic [3:0]            posit_o,
  output logic                  NaR_o,
  output logic                  zero_o,
  output logic                  sow_o,
  output logic                  eow_o
);
  localparam int LPW = $clog2(QUIRE_SIZE);
  localparam int NW  = QUIRE_SIZE - 1;

  logic process_en, receive_en;

  logic                  skid_vld, skid_nar, skid_sow, skid_eow;
  logic [QUIRE_SIZE-1:0] skid_data;

  logic                  src_take, src_nar, src_sow, src_eow;
  logic [QUIRE_SIZE-1:0] src_data;

  logic                  s0_vld, s0_nar, s0_sow, s0_eow;
  logic [QUIRE_SIZE-1:0] s0_data;

  logic                  s1_vld, s1_sign, s1_nar, s1_zero, s1_sow, s1_eow;
  logic [QUIRE_SIZE-1:0] s1_mag;

  logic       s2_vld, s2_sign, s2_nar, s2_zero, s2_sow, s2_eow, s2_sat, s2_sticky;
  logic [2:0] s2_scale, s2_frac;

  logic [LPW-1:0] lead, shamt;
  logic [NW-1:0]  norm;
  logic [2:0]     body;
  logic           guard, rsticky;
  logic [3:0]     rounded, pos, enc;

  assign process_en = rtr_i | ~rts_o;
  assign receive_en = rts_i & rtr_o;

  // The skid entry, when present, is always older than anything on the live inputs.
  assign src_take = skid_vld | receive_en;
  assign src_data = skid_vld ? skid_data : data_i;
  assign src_nar  = skid_vld ? skid_nar  : NaR_i;
  assign src_sow  = skid_vld ? skid_sow  : sow_i;
  assign src_eow  = skid_vld ? skid_eow  : eow_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtr_o     <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_nar  <= 1'b0;
      skid_sow  <= 1'b0;
      skid_eow  <= 1'b0;
    end else begin
      rtr_o <= process_en;
      if (receive_en && !process_en) begin
        skid_vld  <= 1'b1;
        skid_data <= data_i;
        skid_nar  <= NaR_i;
        skid_sow  <= sow_i;
        skid_eow  <= eow_i;
      end else if (process_en) begin
        skid_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    lead = '0;
    for (int i = 0; i < QUIRE_SIZE; i++)
      if (s1_mag[i]) lead = LPW'(i);
  end

  // Shift so the leading one lands just above the kept bits; the hidden bit falls off the top.
  assign shamt = LPW'(QUIRE_SIZE - 1) - lead;
  assign norm  = NW'(s1_mag << shamt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld    <= 1'b0;
      s0_data   <= '0;
      s0_nar    <= 1'b0;
      s0_sow    <= 1'b0;
      s0_eow    <= 1'b0;
      s1_vld    <= 1'b0;
      s1_sign   <= 1'b0;
      s1_nar    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_sow    <= 1'b0;
      s1_eow    <= 1'b0;
      s1_mag    <= '0;
      s2_vld    <= 1'b0;
      s2_sign   <= 1'b0;
      s2_nar    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_sow    <= 1'b0;
      s2_eow    <= 1'b0;
      s2_sat    <= 1'b0;
      s2_scale  <= '0;
      s2_frac   <= '0;
      s2_sticky <= 1'b0;
    end else if (process_en) begin
      s0_vld  <= src_take & (~EOW_ONLY | src_eow);
      s0_data <= src_data;
      s0_nar  <= src_nar;
      s0_sow  <= src_sow;
      s0_eow  <= src_eow;

      s1_vld  <= s0_vld;
      s1_sign <= s0_data[QUIRE_SIZE-1];
      s1_nar  <= s0_nar;
      s1_zero <= (s0_data == '0);
      s1_sow  <= s0_sow;
      s1_eow  <= s0_eow;
      s1_mag  <= s0_data[QUIRE_SIZE-1] ? (~s0_data + QUIRE_SIZE'(1)) : s0_data;

      s2_vld    <= s1_vld;
      s2_sign   <= s1_sign;
      s2_nar    <= s1_nar;
      s2_zero   <= s1_zero;
      s2_sow    <= s1_sow;
      s2_eow    <= s1_eow;
      s2_sat    <= (lead >= LPW'(6));
      s2_scale  <= lead[2:0] - 3'd4;
      s2_frac   <= norm[NW-1 -: 3];
      s2_sticky <= |norm[NW-4:0];
    end
  end

  // s2_scale is the two's-complement scale -4..1; scale >= 2 is carried by s2_sat.
  always_comb begin
    body    = 3'b000;
    guard   = 1'b0;
    rsticky = 1'b0;
    case (s2_scale)
      3'b001: begin
        body    = 3'b110;
        guard   = s2_frac[2];
        rsticky = |s2_frac[1:0] | s2_sticky;
      end
      3'b000: begin
        body    = {2'b10, s2_frac[2]};
        guard   = s2_frac[1];
        rsticky = s2_frac[0] | s2_sticky;
      end
      3'b111: begin
        body    = {2'b01, s2_frac[2]};
        guard   = s2_frac[1];
        rsticky = s2_frac[0] | s2_sticky;
      end
      3'b110: begin
        body    = 3'b001;
        guard   = s2_frac[2];
        rsticky = |s2_frac[1:0] | s2_sticky;
      end
      3'b101: begin
        body    = 3'b000;
        guard   = 1'b1;
        rsticky = |s2_frac | s2_sticky;
      end
      default: begin
        body    = 3'b000;
        guard   = 1'b0;
        rsticky = 1'b1;
      end
    endcase
    rounded = {1'b0, body} + {3'b000, guard & (rsticky | body[0])};
    if (s2_sat || rounded[3]) pos = 4'b0111;
    else if (rounded[2:0] == 3'b000) pos = 4'b0001;
    else pos = {1'b0, rounded[2:0]};
    enc = s2_sign ? (~pos + 4'd1) : pos;
    if (s2_nar) enc = 4'b1000;
    else if (s2_zero) enc = 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rts_o   <= 1'b0;
      posit_o <= 4'b0000;
      NaR_o   <= 1'b0;
      zero_o  <= 1'b0;
      sow_o   <= 1'b0;
      eow_o   <= 1'b0;
    end else if (process_en) begin
      rts_o   <= s2_vld;
      posit_o <= enc;
      NaR_o   <= s2_nar;
      zero_o  <= s2_zero & ~s2_nar;
      sow_o   <= s2_sow;
      eow_o   <= s2_eow;
    end
  end

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// Bench for quire_to_posit_4_0: one instance with EOW_ONLY=1, one with EOW_ONLY=0, selected by sel.
// Expected posits come from a value-domain nearest-even model over the posit<4,0> value table.
module tb_quire_to_posit_4_0;
  localparam int Q = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic rts_i = 1'b0, sow_i = 1'b0, eow_i = 1'b0, nar_i = 1'b0, rtr_i = 1'b0;
  logic [Q-1:0] data_i = '0;

  logic a_rts_i, a_rtr_o, a_rts_o, a_nar_o, a_zero_o, a_sow_o, a_eow_o;
  logic b_rts_i, b_rtr_o, b_rts_o, b_nar_o, b_zero_o, b_sow_o, b_eow_o;
  logic [3:0] a_posit, b_posit;
  logic m_rtr, m_rts;
  logic [7:0] m_out;

  int checks = 0;
  int failures = 0;

  logic [Q-1:0] q_d[$];
  logic q_n[$], q_s[$], q_e[$];
  logic [7:0] e_out[$];

  assign a_rts_i = rts_i & ~sel;
  assign b_rts_i = rts_i & sel;
  assign m_rtr = sel ? b_rtr_o : a_rtr_o;
  assign m_rts = sel ? b_rts_o : a_rts_o;
  assign m_out = sel ? {b_posit, b_nar_o, b_zero_o, b_sow_o, b_eow_o}
                     : {a_posit, a_nar_o, a_zero_o, a_sow_o, a_eow_o};

  always #5 clk = ~clk;

  quire_to_posit_4_0 #(.LOG_NB_ACCUM(10), .EOW_ONLY(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rts_i(a_rts_i), .rtr_o(a_rtr_o), .sow_i(sow_i), .eow_i(eow_i),
    .data_i(data_i), .NaR_i(nar_i), .rtr_i(rtr_i), .rts_o(a_rts_o), .posit_o(a_posit),
    .NaR_o(a_nar_o), .zero_o(a_zero_o), .sow_o(a_sow_o), .eow_o(a_eow_o));

  quire_to_posit_4_0 #(.LOG_NB_ACCUM(10), .EOW_ONLY(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rts_i(b_rts_i), .rtr_o(b_rtr_o), .sow_i(sow_i), .eow_i(eow_i),
    .data_i(data_i), .NaR_i(nar_i), .rtr_i(rtr_i), .rts_o(b_rts_o), .posit_o(b_posit),
    .NaR_o(b_nar_o), .zero_o(b_zero_o), .sow_o(b_sow_o), .eow_o(b_eow_o));

  // Positive posit<4,0> values scaled by 16 (quire LSB units), indexed by code.
  function automatic logic [3:0] model_posit(input logic [Q-1:0] d, input logic nar);
    int tbl[8] = '{0, 4, 8, 12, 16, 24, 32, 64};
    int v, m, c;
    if (nar) return 4'b1000;
    v = {{(32-Q){d[Q-1]}}, d};
    if (v == 0) return 4'b0000;
    m = (v < 0) ? -v : v;
    c = 1;
    if (m >= 64) c = 7;
    else if (m > 4) begin
      for (int i = 1; i < 7; i++) begin
        if (m > tbl[i] && m <= tbl[i+1]) begin
          if (2*m < tbl[i] + tbl[i+1]) c = i;
          else if (2*m > tbl[i] + tbl[i+1]) c = i + 1;
          else c = (i % 2 == 0) ? i : i + 1;
        end
      end
    end
    return (v < 0) ? 4'(16 - c) : 4'(c);
  endfunction

  function automatic logic [Q-1:0] rand_data();
    int k, v;
    logic [Q-1:0] d;
    k = int'($urandom_range(9));
    if (k < 5) begin
      v = int'($urandom_range(160)) - 80;
      d = v[Q-1:0];
    end else if (k < 7) begin
      d = Q'($urandom) >> $urandom_range(18);
      if ($urandom_range(1) == 1) d = -d;
    end else if (k == 7) d = '0;
    else if (k == 8) d = {1'b1, {(Q-1){1'b0}}};
    else d = Q'($urandom);
    return d;
  endfunction

  task automatic push_item(input logic [Q-1:0] d, input logic n, input logic s, input logic e);
    logic [3:0] p;
    q_d.push_back(d);
    q_n.push_back(n);
    q_s.push_back(s);
    q_e.push_back(e);
    if (sel || e) begin
      p = model_posit(d, n);
      e_out.push_back({p, p == 4'b1000, p == 4'b0000, s, e});
    end
  endtask

  // Drives the queued items under the handshake and checks results in order.
  task automatic run_main(input int stall_pct);
    int idx, got, cyc, n, nexp;
    logic acc, prev_stall;
    logic [7:0] held;
    idx = 0; got = 0; cyc = 0; prev_stall = 1'b0; held = '0;
    n = q_d.size(); nexp = e_out.size();
    while ((idx < n || got < nexp) && cyc < 3000) begin
      if (idx < n) begin
        rts_i = 1'b1; data_i = q_d[idx]; nar_i = q_n[idx]; sow_i = q_s[idx]; eow_i = q_e[idx];
      end else rts_i = 1'b0;
      rtr_i = (int'($urandom_range(99)) >= stall_pct);
      if (prev_stall) begin
        checks++;
        if ({m_rts, m_out} !== {1'b1, held})
          $display("FAIL hold: got rts=%0b out=%h required rts=1 out=%h", m_rts, m_out, held);
      end
      prev_stall = 1'b0;
      if (m_rts) begin
        if (rtr_i) begin
          checks++;
          if (got >= nexp) begin
            failures++;
            $display("FAIL extra_output: got out=%h required no output", m_out);
          end else if (m_out !== e_out[got]) begin
            failures++;
            $display("FAIL result[%0d]: got {posit,nar,zero,sow,eow}=%h required %h (data=%h nar=%0b)",
                     got, m_out, e_out[got], q_d[got < n ? got : 0], q_n[got < n ? got : 0]);
          end
          got++;
        end else begin
          prev_stall = 1'b1;
          held = m_out;
        end
      end
      acc = rts_i & m_rtr;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    checks++;
    if (idx < n || got < nexp) begin
      failures++;
      $display("FAIL stream_timeout: accepted %0d of %0d, got %0d of %0d outputs", idx, n, got, nexp);
    end
    rts_i = 1'b0; rtr_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (m_rts !== 1'b0) begin
        failures++;
        $display("FAIL trailing_output: got rts=%0b out=%h required rts=0", m_rts, m_out);
      end
      @(posedge clk); #1;
    end
    q_d.delete(); q_n.delete(); q_s.delete(); q_e.delete(); e_out.delete();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({a_rts_o, a_rtr_o, a_posit, a_nar_o, a_zero_o, a_sow_o, a_eow_o,
         b_rts_o, b_rtr_o, b_posit, b_nar_o, b_zero_o, b_sow_o, b_eow_o} !== 20'h0) begin
      failures++;
      $display("FAIL reset_values: got a=%b%b%h%b%b%b%b b=%b%b%h%b%b%b%b required all zero",
               a_rts_o, a_rtr_o, a_posit, a_nar_o, a_zero_o, a_sow_o, a_eow_o,
               b_rts_o, b_rtr_o, b_posit, b_nar_o, b_zero_o, b_sow_o, b_eow_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_rtr_o !== 1'b0) begin
      failures++;
      $display("FAIL rtr_before_edge: got %0b required 0", a_rtr_o);
    end
    @(posedge clk); #1;
    checks++;
    if (a_rtr_o !== 1'b1 || b_rtr_o !== 1'b1) begin
      failures++;
      $display("FAIL rtr_first_edge: got a=%0b b=%0b required 1 1", a_rtr_o, b_rtr_o);
    end
  endtask

  task automatic test_directed();
    int vals[13] = '{16, -16, 24, 12, 28, 48, 49, 2, 1, 131072, 0, -262144, 0};
    sel = 1'b0;
    for (int i = 0; i < 13; i++) push_item(Q'(vals[i]), i == 12, 1'b1, 1'b1);
    push_item(Q'(16), 1'b1, 1'b0, 1'b1);
    run_main(0);
  endtask

  task automatic test_latency(input logic [Q-1:0] d);
    int k;
    logic [3:0] p;
    p = model_posit(d, 1'b0);
    rtr_i = 1'b1; k = 0;
    while (!m_rtr && k < 10) begin @(posedge clk); #1; k++; end
    rts_i = 1'b1; data_i = d; nar_i = 1'b0; sow_i = 1'b1; eow_i = 1'b1;
    @(posedge clk); #1;
    rts_i = 1'b0; k = 0;
    while (!m_rts && k < 10) begin @(posedge clk); #1; k++; end
    checks++;
    if (k != 3 || m_out[7:4] !== p) begin
      failures++;
      $display("FAIL latency: got %0d cycles posit=%b required 3 cycles posit=%b", k, m_out[7:4], p);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_window();
    logic [Q-1:0] w[8];
    for (int i = 0; i < 8; i++) w[i] = rand_data();
    sel = 1'b0;
    for (int i = 0; i < 8; i++) push_item(w[i], 1'b0, i == 0, i == 7);
    run_main(0);
    sel = 1'b1;
    for (int i = 0; i < 8; i++) push_item(w[i], 1'b0, i == 0, i == 7);
    run_main(0);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    for (int i = 0; i < 30; i++)
      push_item(rand_data(), $urandom_range(11) == 0, $urandom_range(3) == 0, $urandom_range(9) < 4);
    run_main(0);
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    for (int i = 0; i < 40; i++)
      push_item(rand_data(), $urandom_range(11) == 0, $urandom_range(3) == 0, $urandom_range(9) < 5);
    run_main(50);
    sel = 1'b1;
    for (int i = 0; i < 30; i++)
      push_item(rand_data(), $urandom_range(11) == 0, $urandom_range(3) == 0, $urandom_range(9) < 3);
    run_main(50);
    sel = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int cnt, k;
    logic acc, busy;
    sel = 1'b0;
    rtr_i = 1'b1; rts_i = 1'b1; data_i = Q'(16); nar_i = 1'b0; sow_i = 1'b0; eow_i = 1'b1;
    cnt = 0; k = 0;
    while (cnt < 5 && k < 20) begin
      acc = rts_i & m_rtr;
      @(posedge clk); #1;
      if (acc) cnt++;
      k++;
    end
    rts_i = 1'b0;
    busy = a_rts_o;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!busy || {a_rts_o, a_rtr_o, a_posit, a_nar_o, a_zero_o, a_sow_o, a_eow_o} !== 10'h0) begin
      failures++;
      $display("FAIL midstream_reset: busy_before=%0b got rts=%0b rtr=%0b posit=%b required busy=1, all zero",
               busy, a_rts_o, a_rtr_o, a_posit);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (a_rts_o !== 1'b0) begin
        failures++;
        $display("FAIL stale_after_reset: got rts=%0b posit=%b required rts=0", a_rts_o, a_posit);
      end
    end
    test_latency(Q'(24));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_latency(Q'(16));
    test_latency(Q'(-12));
    test_window();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quire_to_posit_4_0.md
# quire_to_posit_4_0

Converts the 19-bit two's-complement quire of the posit<4,0> accumulator into a rounded 4-bit posit<4,0>. It sits directly downstream of the quire accumulator and consumes its rts/rtr stream (data, NaR, sow, eow). It normalises the quire through a 3-stage pipeline with round-to-nearest-even and posit saturation. It emits one posit per end-of-window, or per input when so configured.

## Interface
- LOG_NB_ACCUM, 10, accumulation headroom bits; QUIRE_SIZE = 9 + LOG_NB_ACCUM (19 by default).
- EOW_ONLY, 1, 1: only inputs with eow_i=1 are converted and all others are consumed and dropped; 0: every input is converted.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low; clock clk.
- rts_i  in  1  upstream has valid data.
- rtr_o  out  1  ready to receive (registered).
- sow_i  in  1  start of window tag.
- eow_i  in  1  end of window tag.
- data_i  in  QUIRE_SIZE  quire value, two's complement, binary point between bits 4 and 3 (value = data_i·2^-4).
- NaR_i  in  1  quire is NaR.
- rtr_i  in  1  downstream ready.
- rts_o  out  1  posit_o valid.
- posit_o  out  4  posit<4,0> result.
- NaR_o  out  1  posit_o == 4'b1000.
- zero_o  out  1  posit_o == 4'b0000.
- sow_o, eow_o  out  1  tags forwarded with the datum.

## Operation
- process_en = rtr_i | ~rts_o.
- receive_en = rts_i & rtr_o.
- rtr_o <= process_en each clock.
- Skid register:
  - Loaded with one item when receive_en & ~process_en.
  - Has priority over the live inputs; released when process_en.
- Drop rule: with EOW_ONLY=1, an accepted item with eow=0 is consumed but enters stage 1 as a bubble.
- Stage 1, magnitude:
  - mag = |data_i|, computed in QUIRE_SIZE bits unsigned; -2^(QUIRE_SIZE-1) yields 2^(QUIRE_SIZE-1).
  - Register sign = data_i[MSB], NaR, and zero = (data_i == 0).
- Stage 2, normalise:
  - Leading-one detect on mag gives position p; scale s = p - 4, range -4..QUIRE_SIZE-5.
  - Left-shift mag so the hidden bit is dropped; keep 3 fraction bits plus sticky (OR of all lower bits).
- Stage 3, encode:
  - Regime: s ≥ 0 gives s+1 ones then 0; s < 0 gives -s zeros then 1. Fraction bits follow.
  - Take the first 3 bits after the sign bit as body. guard = next bit; sticky = OR of all remaining bits.
  - Round up when guard & (sticky | body[0]).
  - Saturate: s ≥ 2, or a round-up past 3'b111, gives 0111 (maxpos = 4). A nonzero body that rounds to 000 gives 0001 (minpos).
  - Negative results: posit_o = two's complement of the positive encoding.
- Overrides: NaR gives 1000 (NaR_o=1); zero gives 0000 (zero_o=1). NaR wins over zero.
- Stall: when process_en=0, all stages and outputs hold.

## Timing
- Reset values: rts_o=0, rtr_o=0, posit_o=0, NaR_o=0, zero_o=0, sow_o=0, eow_o=0, skid register empty.
- rtr_o rises on the first clk edge after reset release.
- Latency: an item accepted at edge N shows rts_o=1 with its result after edge N+3, with no stall.
- Throughput: 1 item/clk.
- rts_o stays high and data stays stable until rtr_i=1.
- Simultaneous rts_i, rtr_o=1, process_en=0: the item goes to the skid register; rtr_o is 0 the next cycle. No loss, no duplication.
- Dropped items produce no rts_o pulse.
- rst_n asserted mid-stream clears all stages immediately, including in-flight items.

## Test plan
- data_i=16 (1.0), eow=1 -> posit_o=0100 after 3 cycles; data_i=-16 -> 1100; 24 (1.5) -> 0101; 12 (0.75) -> 0011.
- Rounding: 28 (1.75) -> 0110; 48 (3.0, tie) -> 0110; 49 -> 0111; 2 (1/8) -> 0001; 1 -> 0001; 2^17 -> 0111.
- Specials: data_i=0 -> 0000 with zero_o=1; NaR_i=1 with any data -> 1000 with NaR_o=1; data_i=-2^18 -> 1001.
- EOW_ONLY=1: window of 8 items with eow only on the last -> exactly one rts_o pulse carrying the last item's result. EOW_ONLY=0 -> 8 outputs in order.
- Backpressure: rtr_i random 50% while rts_i is held high -> output sequence identical to the no-stall run, with no drops or duplicates and outputs held during stalls.
- Reset asserted with 3 items in flight -> all outputs 0 at once; after release, the first accepted item's result appears alone, 3 cycles after acceptance.
